// File: rtl/disp_src_sched_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared types and helpers for the seven-segment display source scheduler.
//   disp_state_t : scheduler state (EMPTY = nothing to show, SHOW = cur_src valid)
//   nv_t         : result of a round-robin search (found flag + index)
//   next_valid() : round-robin successor of an index within a valid mask
// -----------------------------------------------------------------------------
package disp_pkg;

    localparam int DATA_W  = 32;
    // Largest supported source count; the search helper works on masks this wide.
    localparam int MAX_SRC = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        SHOW  = 1'b1
    } disp_state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } nv_t;

    // Searches idx+1, idx+2, ... wrapping at nsrc, and finally idx itself.
    // Including idx as the last candidate means "no other valid source" returns
    // idx unchanged, and a search from nsrc-1 yields the lowest valid index.
    function automatic nv_t next_valid(input logic [2:0]         idx,
                                       input logic [MAX_SRC-1:0] valid_mask,
                                       input int                 nsrc);
        nv_t r;
        int  j;
        r = '0;
        for (int k = 1; k <= MAX_SRC; k++) begin
            if (k <= nsrc && !r.found) begin
                j = int'(idx) + k;
                if (j >= nsrc) j = j - nsrc;
                if (valid_mask[j[2:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j[2:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/disp_src_sched_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronises a raw push-button and accepts a new level only after it has
// been seen DEBOUNCE consecutive cycles at the synchroniser output.
// Ports:
//   clk   in  system clock
//   clr   in  asynchronous active-high reset (button treated as released)
//   raw   in  raw, asynchronous button level
//   level out accepted (debounced) level
//   press out one-cycle pulse on an accepted 0->1 transition
// Press is decoded from registered state in the same cycle the new level is
// accepted, so it reaches the consumer 2 + DEBOUNCE cycles after the raw edge.
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE = 1_000_000
) (
    input  logic clk,
    input  logic clr,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int            CW       = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    // cnt_q holds how many earlier samples already differed from the accepted
    // level; the current differing sample completes the run of DEBOUNCE.
    assign accept = (sync2_q != level_q) && (cnt_q == CNT_LAST);

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (accept) level_d = sync2_q;
            else        cnt_d   = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = accept && sync2_q;

endmodule

// File: rtl/disp_src_sched.sv
// -----------------------------------------------------------------------------
// disp_src_sched
// Shares one 8-digit seven-segment display among NSRC 32-bit debug sources.
// Auto mode rotates through valid sources every DWELL cycles; manual mode
// steps on a debounced button press. A second button toggles the mode.
// Ports:
//   clk        in   system clock
//   clr        in   asynchronous active-high reset
//   src_data   in   packed source words, source i at [32*i+31:32*i]
//   src_valid  in   per-source valid; invalid sources are skipped
//   btn_next   in   raw button: advance to next source (manual mode)
//   btn_mode   in   raw button: toggle auto/manual
//   freeze     in   while high, disp_data/disp_valid hold
//   disp_data  out  registered word for the display driver
//   cur_src    out  index of the selected source
//   auto_mode  out  1 = auto rotate, 0 = manual
//   disp_valid out  0 when no source is valid
// -----------------------------------------------------------------------------
module disp_src_sched
    import disp_pkg::*;
#(
    parameter int NSRC     = 4,
    parameter int DWELL    = 100_000_000,
    parameter int DEBOUNCE = 1_000_000,
    parameter int IDXW     = $clog2(NSRC)
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [NSRC*DATA_W-1:0] src_data,
    input  logic [NSRC-1:0]        src_valid,
    input  logic                   btn_next,
    input  logic                   btn_mode,
    input  logic                   freeze,
    output logic [DATA_W-1:0]      disp_data,
    output logic [IDXW-1:0]        cur_src,
    output logic                   auto_mode,
    output logic                   disp_valid
);

    localparam int            DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    disp_state_t          state_q, state_d;
    logic [IDXW-1:0]      cur_q, cur_d;
    logic                 auto_q, auto_d;
    logic [DW-1:0]        dwell_q, dwell_d;
    logic [DATA_W-1:0]    data_q;
    logic                 dvalid_q;

    logic                 next_press, mode_press;
    logic                 next_lvl, mode_lvl;
    logic                 unused_lvl;
    logic [MAX_SRC-1:0]   mask8;
    logic [2:0]           cur3;
    nv_t                  succ, first;
    logic                 advance;
    logic [DATA_W-1:0]    sel_word;

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_next (
        .clk   (clk),
        .clr   (clr),
        .raw   (btn_next),
        .level (next_lvl),
        .press (next_press)
    );

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_mode (
        .clk   (clk),
        .clr   (clr),
        .raw   (btn_mode),
        .level (mode_lvl),
        .press (mode_press)
    );

    // Only the press pulses are used here; the levels are kept for debug taps.
    assign unused_lvl = next_lvl ^ mode_lvl;

    always_comb begin
        mask8             = '0;
        mask8[NSRC-1:0]   = src_valid;
        cur3              = '0;
        cur3[IDXW-1:0]    = cur_q;
    end

    // succ: round-robin successor of cur_src (cur_src itself if it is the only
    // valid one). first: lowest valid index, used when leaving EMPTY.
    assign succ  = next_valid(cur3, mask8, NSRC);
    assign first = next_valid(3'(NSRC - 1), mask8, NSRC);

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        auto_d  = auto_q ^ mode_press;
        dwell_d = dwell_q;
        advance = 1'b0;
        if (state_q == EMPTY) begin
            dwell_d = '0;
            if (first.found) begin
                state_d = SHOW;
                cur_d   = first.idx[IDXW-1:0];
            end
        end else if (!mask8[cur3]) begin
            // Selected source went away: reselect, or fall back to EMPTY.
            dwell_d = '0;
            if (succ.found) cur_d   = succ.idx[IDXW-1:0];
            else            state_d = EMPTY;
        end else if (mode_press) begin
            // A mode toggle takes priority over a coincident dwell expiry.
            dwell_d = '0;
        end else begin
            advance = auto_q ? (dwell_q == DWELL_LAST) : next_press;
            if (advance) begin
                cur_d   = succ.idx[IDXW-1:0];
                dwell_d = '0;
            end else if (auto_q) begin
                dwell_d = dwell_q + DW'(1);
            end
        end
    end

    always_comb begin
        sel_word = src_data[cur_q*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= EMPTY;
            cur_q    <= '0;
            auto_q   <= 1'b1;
            dwell_q  <= '0;
            data_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            auto_q  <= auto_d;
            dwell_q <= dwell_d;
            if (!freeze) begin
                dvalid_q <= (state_q == SHOW);
                data_q   <= (state_q == SHOW) ? sel_word : '0;
            end
        end
    end

    assign disp_data  = data_q;
    assign disp_valid = dvalid_q;
    assign cur_src    = cur_q;
    assign auto_mode  = auto_q;

endmodule

// File: tb/tb_disp_src_sched.sv
// -----------------------------------------------------------------------------
// tb_disp_src_sched
// Directed bench for disp_src_sched (NSRC=4, DWELL=8, DEBOUNCE=4). A
// behavioural model tracks the expected outputs from the scheduling rules;
// every cycle the DUT is compared against it, and literal expectations at key
// points pin both DUT and model.
// -----------------------------------------------------------------------------
module tb_disp_src_sched;

    localparam int NSRC  = 4;
    localparam int DWELL = 8;
    localparam int DB    = 4;
    localparam int IDXW  = 2;

    logic                 clk = 1'b0;
    logic                 clr;
    logic [NSRC*32-1:0]   src_data;
    logic [NSRC-1:0]      src_valid;
    logic                 btn_next, btn_mode, freeze;
    logic [31:0]          disp_data;
    logic [IDXW-1:0]      cur_src;
    logic                 auto_mode, disp_valid;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    always #5 clk = ~clk;

    disp_src_sched #(
        .NSRC     (NSRC),
        .DWELL    (DWELL),
        .DEBOUNCE (DB)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .btn_next   (btn_next),
        .btn_mode   (btn_mode),
        .freeze     (freeze),
        .disp_data  (disp_data),
        .cur_src    (cur_src),
        .auto_mode  (auto_mode),
        .disp_valid (disp_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_show   = 1'b0;
    int          m_cur    = 0;
    logic        m_auto   = 1'b1;
    int          m_dwell  = 0;
    logic [31:0] m_data   = '0;
    logic        m_dvalid = 1'b0;
    logic        hm [16];
    logic        hn [16];
    logic        lm = 1'b0, ln = 1'b0;
    logic        pm, pn, all1m, all0m, all1n, all0n, old_auto;
    int          nxt, lo;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_show = 1'b0; m_cur = 0; m_auto = 1'b1; m_dwell = 0;
            m_data = '0; m_dvalid = 1'b0; lm = 1'b0; ln = 1'b0;
            for (int i = 0; i < 16; i++) begin hm[i] = 1'b0; hn[i] = 1'b0; end
        end else begin
            // Button history: h[0] is this edge's raw sample; a press is
            // recognised when raw samples from 2..DB+1 edges ago are all 1.
            for (int i = 15; i > 0; i--) begin hm[i] = hm[i-1]; hn[i] = hn[i-1]; end
            hm[0] = btn_mode; hn[0] = btn_next;
            all1m = 1'b1; all0m = 1'b1; all1n = 1'b1; all0n = 1'b1;
            for (int i = 2; i <= DB + 1; i++) begin
                if (hm[i] !== 1'b1) all1m = 1'b0;
                if (hm[i] !== 1'b0) all0m = 1'b0;
                if (hn[i] !== 1'b1) all1n = 1'b0;
                if (hn[i] !== 1'b0) all0n = 1'b0;
            end
            pm = all1m && !lm;
            pn = all1n && !ln;
            if (all1m) lm = 1'b1; else if (all0m) lm = 1'b0;
            if (all1n) ln = 1'b1; else if (all0n) ln = 1'b0;

            if (!freeze) begin
                m_dvalid = m_show;
                m_data   = m_show ? src_data[m_cur*32 +: 32] : 32'h0;
            end

            nxt = -1;
            for (int k = 1; k <= NSRC; k++)
                if (nxt < 0 && src_valid[(m_cur + k) % NSRC]) nxt = (m_cur + k) % NSRC;
            lo = -1;
            for (int i = 0; i < NSRC; i++)
                if (lo < 0 && src_valid[i]) lo = i;

            old_auto = m_auto;
            if (pm) m_auto = !m_auto;

            if (!m_show) begin
                m_dwell = 0;
                if (lo >= 0) begin m_show = 1'b1; m_cur = lo; end
            end else if (!src_valid[m_cur]) begin
                m_dwell = 0;
                if (nxt >= 0) m_cur = nxt; else m_show = 1'b0;
            end else if (pm) begin
                m_dwell = 0;
            end else if (old_auto ? (m_dwell == DWELL - 1) : pn) begin
                m_cur = nxt; m_dwell = 0;
            end else if (old_auto) begin
                m_dwell = m_dwell + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        chk("disp_data",  disp_data,         m_data);
        chk("disp_valid", 32'(disp_valid),   32'(m_dvalid));
        chk("cur_src",    32'(cur_src),      32'(m_cur));
        chk("auto_mode",  32'(auto_mode),    32'(m_auto));
    end

    // ---------------- stimulus ----------------
    task automatic to(input int c);
        while (ncyc < c) begin
            @(negedge clk);
            ncyc++;
        end
    endtask

    task automatic lit(input string name, input logic [31:0] d, input logic [31:0] m,
                       input logic [31:0] e);
        chk({name, " dut"},   d, e);
        chk({name, " model"}, m, e);
    endtask

    initial begin
        clr       = 1'b1;
        src_valid = 4'b1111;
        src_data  = {32'hDDDD_0003, 32'hDDDD_0002, 32'hDDDD_0001, 32'hDDDD_0000};
        btn_next  = 1'b0;
        btn_mode  = 1'b0;
        freeze    = 1'b0;
        repeat (3) @(negedge clk);
        lit("rst cur",   32'(cur_src),    32'(m_cur),    32'd0);
        lit("rst auto",  32'(auto_mode),  32'(m_auto),   32'd1);
        lit("rst data",  disp_data,       m_data,        32'd0);
        lit("rst valid", 32'(disp_valid), 32'(m_dvalid), 32'd0);
        clr  = 1'b0;
        ncyc = 0;

        // Auto rotation over all four sources
        to(1);   lit("t1 cur0",  32'(cur_src), 32'(m_cur), 32'd0);
        to(2);   lit("t1 data0", disp_data, m_data, 32'hDDDD_0000);
                 lit("t1 valid", 32'(disp_valid), 32'(m_dvalid), 32'd1);
        to(9);   lit("t1 cur1",  32'(cur_src), 32'(m_cur), 32'd1);
                 lit("t1 lag",   disp_data, m_data, 32'hDDDD_0000);
        to(10);  lit("t1 data1", disp_data, m_data, 32'hDDDD_0001);
        to(33);  lit("t1 wrap",  32'(cur_src), 32'(m_cur), 32'd0);
                 lit("t1 data3", disp_data, m_data, 32'hDDDD_0003);
        to(34);  lit("t1 data0b", disp_data, m_data, 32'hDDDD_0000);

        // Current source dropped, sparse mask, then empty
        src_valid = 4'b1010;
        to(35);  lit("t2 drop",  32'(cur_src), 32'(m_cur), 32'd1);
        to(43);  lit("t2 cur3",  32'(cur_src), 32'(m_cur), 32'd3);
        to(51);  lit("t2 cur1",  32'(cur_src), 32'(m_cur), 32'd1);
        src_valid = 4'b0000;
        to(52);  lit("t2 vld1",  32'(disp_valid), 32'(m_dvalid), 32'd1);
        to(53);  lit("t2 vld0",  32'(disp_valid), 32'(m_dvalid), 32'd0);
                 lit("t2 data0", disp_data, m_data, 32'd0);
                 lit("t2 hold",  32'(cur_src), 32'(m_cur), 32'd1);
        src_valid = 4'b1111;

        // Debounced mode toggle, glitch rejection, manual step
        to(54);  lit("t3 lowest", 32'(cur_src), 32'(m_cur), 32'd0);
        to(55);  btn_mode = 1'b1;
        to(60);  lit("t3 auto5", 32'(auto_mode), 32'(m_auto), 32'd1);
        to(61);  lit("t3 auto6", 32'(auto_mode), 32'(m_auto), 32'd0);
        to(65);  btn_mode = 1'b0;
        to(72);  btn_next = 1'b1;
        to(75);  btn_next = 1'b0;
        to(85);  lit("t3 glitch", 32'(cur_src), 32'(m_cur), 32'd0);
                 btn_next = 1'b1;
        to(90);  lit("t3 pre",   32'(cur_src), 32'(m_cur), 32'd0);
        to(91);  lit("t3 step",  32'(cur_src), 32'(m_cur), 32'd1);
        to(95);  btn_next = 1'b0;
        to(110); lit("t3 once",  32'(cur_src), 32'(m_cur), 32'd1);
                 btn_mode = 1'b1;

        // Coincident next press / mode press with dwell expiry
        to(116); lit("t4 auto",  32'(auto_mode), 32'(m_auto), 32'd1);
        to(120); btn_mode = 1'b0;
        to(124); lit("t4 cur2",  32'(cur_src), 32'(m_cur), 32'd2);
        to(126); btn_next = 1'b1;
        to(131); lit("t4 pre",   32'(cur_src), 32'(m_cur), 32'd2);
        to(132); lit("t4 single", 32'(cur_src), 32'(m_cur), 32'd3);
        to(136); btn_next = 1'b0;
        to(139); lit("t4 hold3", 32'(cur_src), 32'(m_cur), 32'd3);
        to(140); lit("t4 cur0",  32'(cur_src), 32'(m_cur), 32'd0);
        to(142); btn_mode = 1'b1;
        to(147); lit("t4 preM",  32'(auto_mode), 32'(m_auto), 32'd1);
        to(148); lit("t4 modeW", 32'(auto_mode), 32'(m_auto), 32'd0);
                 lit("t4 noadv", 32'(cur_src), 32'(m_cur), 32'd0);
        to(152); btn_mode = 1'b0;
        to(160); lit("t4 man",   32'(cur_src), 32'(m_cur), 32'd0);
                 btn_mode = 1'b1;

        // Freeze holds display while selection keeps rotating
        to(166); lit("t5 auto",  32'(auto_mode), 32'(m_auto), 32'd1);
        to(170); btn_mode = 1'b0;
        to(182); lit("t5 cur2",  32'(cur_src), 32'(m_cur), 32'd2);
        to(183); lit("t5 data2", disp_data, m_data, 32'hDDDD_0002);
        to(184); freeze = 1'b1;
                 src_data[2*32 +: 32] = 32'h1234_5678;
        to(190); lit("t5 rot",   32'(cur_src), 32'(m_cur), 32'd3);
                 lit("t5 frz",   disp_data, m_data, 32'hDDDD_0002);
        to(200); lit("t5 frz2",  disp_data, m_data, 32'hDDDD_0002);
                 freeze = 1'b0;
        to(201); lit("t5 thaw",  disp_data, m_data, 32'hDDDD_0000);
        to(214); lit("t5 cur2b", 32'(cur_src), 32'(m_cur), 32'd2);
        to(215); lit("t5 newW",  disp_data, m_data, 32'h1234_5678);
        to(216); btn_mode = 1'b1;

        // Async clear in manual mode, then restart
        to(222); lit("t6 man",   32'(auto_mode), 32'(m_auto), 32'd0);
                 lit("t6 cur2",  32'(cur_src), 32'(m_cur), 32'd2);
        to(226); btn_mode = 1'b0;
        to(232); clr = 1'b1;
        #1;
        lit("t6 clr cur",   32'(cur_src),    32'(m_cur),    32'd0);
        lit("t6 clr auto",  32'(auto_mode),  32'(m_auto),   32'd1);
        lit("t6 clr data",  disp_data,       m_data,        32'd0);
        lit("t6 clr valid", 32'(disp_valid), 32'(m_dvalid), 32'd0);
        to(234); clr = 1'b0;
        ncyc = 0;
        to(1);   lit("t6 cur0",  32'(cur_src), 32'(m_cur), 32'd0);
        to(2);   lit("t6 data0", disp_data, m_data, 32'hDDDD_0000);
        to(9);   lit("t6 cur1",  32'(cur_src), 32'(m_cur), 32'd1);
                 lit("t6 auto1", 32'(auto_mode), 32'(m_auto), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_src_sched.md
Name: disp_src_sched

Overview:
Scheduler that shares the 8-digit seven-segment display between NSRC 32-bit debug sources, such as PC, ALU result, register-file read and memory word.
- Selects one valid source, registers its value and drives the display driver's 32-bit data input.
- Auto mode rotates sources on a dwell timer; manual mode steps on a debounced button.
- Sits between the CPU debug taps and the seven-segment driver in the board top level.

Parameters:
NSRC, 4, number of requesting sources (2..8)
DWELL, 100_000_000, clock cycles each source is shown in auto mode
DEBOUNCE, 1_000_000, cycles a raw button level must be stable to be accepted
IDXW, $clog2(NSRC), width of source index (derived, not overridden)

Ports:
clk  in  1  system clock
clr  in  1  asynchronous active-high reset
src_data  in  NSRC*32  packed source words; source i occupies bits [32*i+31:32*i]
src_valid  in  NSRC  per-source valid; invalid sources are skipped
btn_next  in  1  raw push-button, advance to next source (manual mode)
btn_mode  in  1  raw push-button, toggle auto/manual
freeze  in  1  level; while high, disp_data holds its last value
disp_data  out  32  value to seven-segment driver data input
cur_src  out  IDXW  index of the currently selected source
auto_mode  out  1  1 = auto rotate, 0 = manual
disp_valid  out  1  0 when no source is valid (display shows 0)

Behaviour:
- Reset (clr high, async): cur_src=0, auto_mode=1, disp_data=0, disp_valid=0, dwell counter=0, both debouncers cleared to "released".
- Debounce: each button passes through a 2-flop synchroniser and then a stability counter.
  - The accepted level changes only after DEBOUNCE consecutive equal samples.
  - A one-cycle press pulse is emitted on an accepted 0->1 transition.
  - Press latency is 2 + DEBOUNCE cycles from the raw edge.
- mode pulse: toggles auto_mode and clears the dwell counter.
- FSM states:
  - EMPTY: no src_valid bit set.
  - SHOW: cur_src is valid.
- EMPTY transitions:
  - disp_valid=0, disp_data=0, cur_src holds.
  - When any src_valid bit rises, go to SHOW with cur_src = lowest-index valid source.
- SHOW, advance event = (auto_mode && dwell == DWELL-1) || (!auto_mode && next pulse).
  - Advance: cur_src becomes the next valid index after cur_src, round-robin with wrap from NSRC-1 to 0.
  - If no other source is valid, cur_src holds. The dwell counter clears on every advance event.
- next pulse in auto mode is ignored. Dwell does not count in manual mode, and the counter holds at 0.
- Dwell expiry and a next pulse in the same cycle produce exactly one advance.
- Dwell expiry and a mode pulse in the same cycle: the mode toggle wins, no advance, dwell cleared.
- Current source drops valid while in SHOW:
  - On the next cycle, move to the next valid source (same search as advance) and clear dwell.
  - If none is valid, go to EMPTY.
- Data path, when freeze=0:
  - disp_data <= src_data[cur_src] every cycle, using registered cur_src.
  - Latency from a cur_src change to disp_data update is 1 cycle. disp_valid <= (state==SHOW).
- When freeze=1: disp_data and disp_valid hold. Selection and dwell continue, so cur_src may still change.
- Dwell counter width is $clog2(DWELL) bits, with no overflow beyond DWELL-1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Decomposition:
- Package disp_pkg:
  - typedef enum {EMPTY, SHOW} disp_state_t
  - localparam DATA_W=32
  - function next_valid(idx, valid_mask) returning the round-robin successor index and a found flag.
- Sub-module btn_debounce, instantiated twice. Parameter DEBOUNCE; ports clk, clr, raw in; level, press out.

Test Plan (bench uses DWELL=8, DEBOUNCE=4, NSRC=4):
1. Reset, src_valid=4'b1111, src_data={D,C,B,A}=32'hDDDD_0003..0000 -> cur_src steps 0,1,2,3,0 every 8 cycles; disp_data follows one cycle after each cur_src change.
2. src_valid=4'b1010 while cur_src=0 -> next cycle cur_src=1; advances go 1->3->1; src_valid=0 -> EMPTY, disp_valid=0, disp_data=0 one cycle later.
3. Press btn_mode for 10 cycles -> auto_mode=0 exactly 6 cycles after the edge; a 3-cycle glitch on btn_next is ignored; a 10-cycle press advances cur_src by exactly 1.
4. In auto mode, align the btn_next pulse with dwell expiry -> single advance of 1. Align the mode pulse with expiry -> no advance, auto_mode toggles.
5. freeze=1 with cur_src=2, change src_data[2] -> disp_data keeps the old value while cur_src continues rotating; freeze=0 -> disp_data equals the current source's word next cycle.
6. Assert clr mid-dwell in manual mode -> immediately cur_src=0, auto_mode=1, disp_data=0, disp_valid=0; after release, normal rotation restarts from 0.
